// File: rtl/dc_pkg.sv
//------------------------------------------------------------------------------
// dc_pkg
// Shared display-controller types: line-responder FSM encoding and DDA widths.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dc_pkg;

    typedef enum logic [1:0] {
        LRR_IDLE = 2'd0,
        LRR_RUN  = 2'd1,
        LRR_DONE = 2'd2
    } lrr_state_e;

    // One guard bit lets acc + step stay below 2^(W+1) without wrapping.
    localparam int DC_ACC_GUARD_BITS = 1;

    function automatic int dc_acc_width(input int coord_width);
        return coord_width + DC_ACC_GUARD_BITS;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dc_ipu_dda_stepper.sv
//------------------------------------------------------------------------------
// dc_ipu_dda_stepper
// Bresenham-style texture coordinate stepper for nearest-neighbour upscaling.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dc_ipu_dda_stepper
    import dc_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             restart,
    input  logic             advance,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] coord
);

    localparam int ACC_W = dc_acc_width(WIDTH);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_sum;
    logic [WIDTH-1:0] r_coord;

    assign w_sum = r_acc + ACC_W'(step);
    assign coord = r_coord;

    // step <= limit is assumed, so at most one coordinate increment per advance.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_acc   <= '0;
            r_coord <= '0;
        end else if (restart) begin
            r_acc   <= '0;
            r_coord <= '0;
        end else if (advance) begin
            if (w_sum >= ACC_W'(limit)) begin
                r_coord <= r_coord + WIDTH'(1);
                r_acc   <= w_sum - ACC_W'(limit);
            end else begin
                r_acc   <= w_sum;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dc_ipu_line_request_responder.sv
//------------------------------------------------------------------------------
// dc_ipu_line_request_responder
// Accepts a line request and emits one pixel descriptor per screen column.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dc_ipu_line_request_responder
    import dc_pkg::*;
#(
    parameter int SCR_SIZE_WIDTH     = 12,
    parameter int SCALE_METHOD_WIDTH = 2,
    parameter int RGB_WIDTH          = 24
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          en,

    input  logic                          ctl_valid,
    output logic                          ctl_ready,
    input  logic [SCR_SIZE_WIDTH-1:0]     ctl_screen_y,
    input  logic [SCR_SIZE_WIDTH-1:0]     ctl_image_offset_x,
    input  logic [SCR_SIZE_WIDTH-1:0]     ctl_image_offset_y,
    input  logic [SCR_SIZE_WIDTH-1:0]     ctl_image_width,
    input  logic [SCR_SIZE_WIDTH-1:0]     ctl_image_height,
    input  logic [SCR_SIZE_WIDTH-1:0]     ctl_screen_width,
    input  logic [SCR_SIZE_WIDTH-1:0]     ctl_tex_width,
    input  logic [SCR_SIZE_WIDTH-1:0]     ctl_tex_height,
    input  logic [SCALE_METHOD_WIDTH-1:0] ctl_scale_method,
    input  logic [RGB_WIDTH-1:0]          ctl_border_color,
    output logic                          status_done,

    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic [SCR_SIZE_WIDTH-1:0]     pix_x,
    output logic [SCR_SIZE_WIDTH-1:0]     pix_y,
    output logic [SCR_SIZE_WIDTH-1:0]     pix_tex_x,
    output logic [SCR_SIZE_WIDTH-1:0]     pix_tex_y,
    output logic                          pix_is_border,
    output logic [RGB_WIDTH-1:0]          pix_color,
    output logic [SCALE_METHOD_WIDTH-1:0] pix_scale_method,
    output logic                          pix_last
);

    localparam int W  = SCR_SIZE_WIDTH;
    localparam int AW = dc_acc_width(SCR_SIZE_WIDTH);

    lrr_state_e r_state;
    lrr_state_e w_state_next;

    logic [W-1:0]                  r_screen_y;
    logic [W-1:0]                  r_off_x;
    logic [W-1:0]                  r_off_y;
    logic [W-1:0]                  r_img_w;
    logic [W-1:0]                  r_img_h;
    logic [W-1:0]                  r_scr_w;
    logic [W-1:0]                  r_tex_w;
    logic [W-1:0]                  r_tex_h;
    logic [SCALE_METHOD_WIDTH-1:0] r_method;
    logic [RGB_WIDTH-1:0]          r_color;
    logic [W-1:0]                  r_x;

    logic         w_accept;
    logic         w_pix_hs;
    logic         w_last;
    logic         w_col_in;
    logic         w_row_in;
    logic         w_pix_in;
    logic         w_x_restart;
    logic         w_x_advance;
    logic         w_y_restart;
    logic         w_y_advance;
    logic [W-1:0] w_tex_x;
    logic [W-1:0] w_tex_y;

    // Window bounds are summed one bit wider so offsets near the top never wrap.
    assign w_col_in = (AW'(r_x) >= AW'(r_off_x)) &&
                      (AW'(r_x) <  AW'(r_off_x) + AW'(r_img_w));
    assign w_row_in = (AW'(r_screen_y) >= AW'(r_off_y)) &&
                      (AW'(r_screen_y) <  AW'(r_off_y) + AW'(r_img_h));
    assign w_pix_in = w_col_in && w_row_in;
    assign w_last   = (r_x == r_scr_w - W'(1));

    assign w_accept = ctl_valid && ctl_ready;
    assign w_pix_hs = pix_valid && pix_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= LRR_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ctl_ready    = 1'b0;
        pix_valid    = 1'b0;
        status_done  = 1'b0;
        case (r_state)
            LRR_IDLE: begin
                ctl_ready = en && nrst;
                if (en && ctl_valid) begin
                    w_state_next = (ctl_screen_width == '0) ? LRR_DONE : LRR_RUN;
                end
            end
            LRR_RUN: begin
                pix_valid = en;
                if (en && pix_ready && w_last) begin
                    w_state_next = LRR_DONE;
                end
            end
            LRR_DONE: begin
                status_done = 1'b1;
                if (en) begin
                    w_state_next = LRR_IDLE;
                end
            end
            default: begin
                w_state_next = LRR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_screen_y <= '0;
            r_off_x    <= '0;
            r_off_y    <= '0;
            r_img_w    <= '0;
            r_img_h    <= '0;
            r_scr_w    <= '0;
            r_tex_w    <= '0;
            r_tex_h    <= '0;
            r_method   <= '0;
            r_color    <= '0;
            r_x        <= '0;
        end else if (w_accept) begin
            r_screen_y <= ctl_screen_y;
            r_off_x    <= ctl_image_offset_x;
            r_off_y    <= ctl_image_offset_y;
            r_img_w    <= ctl_image_width;
            r_img_h    <= ctl_image_height;
            r_scr_w    <= ctl_screen_width;
            r_tex_w    <= ctl_tex_width;
            r_tex_h    <= ctl_tex_height;
            r_method   <= ctl_scale_method;
            r_color    <= ctl_border_color;
            r_x        <= '0;
        end else if (w_pix_hs) begin
            r_x        <= r_x + W'(1);
        end
    end

    // Horizontal stepper re-zeroes on the column that is about to be offset_x.
    assign w_x_restart = w_accept ||
                         (w_pix_hs && (AW'(r_x) + AW'(1) == AW'(r_off_x)));
    assign w_x_advance = w_pix_hs && w_pix_in;

    // At acceptance the latched fields still describe the previous line.
    assign w_y_restart = w_accept && (ctl_screen_y == ctl_image_offset_y);
    assign w_y_advance = w_accept && w_row_in;

    dc_ipu_dda_stepper #(
        .WIDTH   (W)
    ) u_dda_x (
        .clk     (clk),
        .nrst    (nrst),
        .restart (w_x_restart),
        .advance (w_x_advance),
        .step    (r_tex_w),
        .limit   (r_img_w),
        .coord   (w_tex_x)
    );

    dc_ipu_dda_stepper #(
        .WIDTH   (W)
    ) u_dda_y (
        .clk     (clk),
        .nrst    (nrst),
        .restart (w_y_restart),
        .advance (w_y_advance),
        .step    (ctl_tex_height),
        .limit   (ctl_image_height),
        .coord   (w_tex_y)
    );

    assign pix_x            = r_x;
    assign pix_y            = r_screen_y;
    assign pix_is_border    = !w_pix_in;
    assign pix_tex_x        = w_pix_in ? w_tex_x : '0;
    assign pix_tex_y        = w_pix_in ? w_tex_y : '0;
    assign pix_color        = r_color;
    assign pix_scale_method = r_method;
    assign pix_last         = (r_state == LRR_RUN) && w_last;

endmodule

`default_nettype wire

// File: tb/tb_dc_ipu_line_request_responder.sv
//------------------------------------------------------------------------------
// tb_dc_ipu_line_request_responder
// Randomized line requests checked against an arithmetic scaling model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dc_ipu_line_request_responder;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        en = 1'b1;
    logic        ctl_valid = 1'b0;
    logic        ctl_ready;
    logic [11:0] ctl_screen_y = '0;
    logic [11:0] ctl_image_offset_x = '0;
    logic [11:0] ctl_image_offset_y = '0;
    logic [11:0] ctl_image_width = '0;
    logic [11:0] ctl_image_height = '0;
    logic [11:0] ctl_screen_width = '0;
    logic [11:0] ctl_tex_width = '0;
    logic [11:0] ctl_tex_height = '0;
    logic [1:0]  ctl_scale_method = '0;
    logic [23:0] ctl_border_color = '0;
    logic        status_done;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [11:0] pix_x, pix_y, pix_tex_x, pix_tex_y;
    logic        pix_is_border;
    logic [23:0] pix_color;
    logic [1:0]  pix_scale_method;
    logic        pix_last;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: vertical geometry plus in-image lines seen since last restart.
    int g_oy = 0, g_ih = 0, g_th = 0;
    int m_cnt = 0;
    bit m_prev_in = 1'b0;

    always #5 clk = ~clk;

    dc_ipu_line_request_responder dut (
        .clk                (clk),
        .nrst               (nrst),
        .en                 (en),
        .ctl_valid          (ctl_valid),
        .ctl_ready          (ctl_ready),
        .ctl_screen_y       (ctl_screen_y),
        .ctl_image_offset_x (ctl_image_offset_x),
        .ctl_image_offset_y (ctl_image_offset_y),
        .ctl_image_width    (ctl_image_width),
        .ctl_image_height   (ctl_image_height),
        .ctl_screen_width   (ctl_screen_width),
        .ctl_tex_width      (ctl_tex_width),
        .ctl_tex_height     (ctl_tex_height),
        .ctl_scale_method   (ctl_scale_method),
        .ctl_border_color   (ctl_border_color),
        .status_done        (status_done),
        .pix_valid          (pix_valid),
        .pix_ready          (pix_ready),
        .pix_x              (pix_x),
        .pix_y              (pix_y),
        .pix_tex_x          (pix_tex_x),
        .pix_tex_y          (pix_tex_y),
        .pix_is_border      (pix_is_border),
        .pix_color          (pix_color),
        .pix_scale_method   (pix_scale_method),
        .pix_last           (pix_last)
    );

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [79:0] observed();
        return {4'b0, pix_x, pix_y, pix_tex_x, pix_tex_y, pix_is_border, pix_last,
                pix_scale_method, pix_color};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0;
        #1;
        check("rst_ctl_ready", 80'(ctl_ready), 80'(0));
        check("rst_pix_valid", 80'(pix_valid), 80'(0));
        check("rst_done", 80'(status_done), 80'(0));
        @(negedge clk);
        nrst = 1'b1;
        m_cnt = 0;
        m_prev_in = 1'b0;
    endtask

    // mode 0: always ready, 1: ready toggles starting low, 2: random ready
    task automatic run_line(input int y, input int sw, input int ox, input int iw,
                            input int tw, input int mode, input int pause_at,
                            input int abort_at);
        logic [79:0] exp_q[$];
        logic [1:0]  meth;
        logic [23:0] col;
        int idx, vcyc, cyc, tx, ty;
        bit in_px, row_in, paused;
        meth = 2'($urandom_range(0, 3));
        col  = 24'($urandom);
        @(negedge clk);
        ctl_screen_y       = 12'(y);
        ctl_image_offset_x = 12'(ox);
        ctl_image_offset_y = 12'(g_oy);
        ctl_image_width    = 12'(iw);
        ctl_image_height   = 12'(g_ih);
        ctl_screen_width   = 12'(sw);
        ctl_tex_width      = 12'(tw);
        ctl_tex_height     = 12'(g_th);
        ctl_scale_method   = meth;
        ctl_border_color   = col;
        ctl_valid          = 1'b1;
        pix_ready          = 1'b0;
        #1;
        cyc = 0;
        while (!ctl_ready && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (!ctl_ready) begin
            check("accept_timeout", 80'(0), 80'(1));
            ctl_valid = 1'b0;
            return;
        end
        if (y == g_oy) m_cnt = 0;
        else if (m_prev_in) m_cnt++;
        row_in = (y >= g_oy) && (y < g_oy + g_ih);
        m_prev_in = row_in;
        for (int x = 0; x < sw; x++) begin
            in_px = row_in && (x >= ox) && (x < ox + iw);
            tx = in_px ? ((x - ox) * tw) / iw : 0;
            ty = in_px ? (m_cnt * g_th) / g_ih : 0;
            exp_q.push_back({4'b0, 12'(x), 12'(y), 12'(tx), 12'(ty), !in_px,
                             (x == sw - 1), meth, col});
        end
        @(posedge clk);
        @(negedge clk);
        ctl_valid = 1'b0;
        #1;
        check("ready_low_after_accept", 80'(ctl_ready), 80'(0));
        if (sw == 0) begin
            check("zero_no_valid", 80'(pix_valid), 80'(0));
            check("zero_done", 80'(status_done), 80'(1));
            @(negedge clk);
            #1;
            check("zero_done_end", 80'(status_done), 80'(0));
            return;
        end
        check("first_valid", 80'(pix_valid), 80'(1));
        idx = 0; vcyc = 0; cyc = 0; paused = 1'b0;
        while (idx < sw && cyc < 400) begin
            if (idx == abort_at) begin
                nrst = 1'b0;
                pix_ready = 1'b1;
                #1;
                check("abort_valid", 80'(pix_valid), 80'(0));
                check("abort_ready", 80'(ctl_ready), 80'(0));
                @(negedge clk);
                nrst = 1'b1;
                m_cnt = 0;
                m_prev_in = 1'b0;
                repeat (3) begin
                    #1;
                    check("abort_no_done", 80'(status_done), 80'(0));
                    check("abort_no_pix", 80'(pix_valid), 80'(0));
                    @(negedge clk);
                end
                pix_ready = 1'b0;
                return;
            end
            if (idx == pause_at && !paused) begin
                paused = 1'b1;
                en = 1'b0;
                pix_ready = 1'b1;
                repeat (3) begin
                    #1;
                    check("pause_valid", 80'(pix_valid), 80'(0));
                    check("pause_ready", 80'(ctl_ready), 80'(0));
                    @(negedge clk);
                end
                en = 1'b1;
            end
            case (mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = (cyc % 2 == 1);
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            check("pix_valid", 80'(pix_valid), 80'(1));
            check("pix_fields", observed(), exp_q[idx]);
            vcyc++;
            if (pix_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        pix_ready = 1'b0;
        if (idx < sw) begin
            check("pixel_timeout", 80'(idx), 80'(sw));
            return;
        end
        #1;
        check("done_pulse", 80'(status_done), 80'(1));
        check("done_no_valid", 80'(pix_valid), 80'(0));
        check("done_ready_low", 80'(ctl_ready), 80'(0));
        if (mode == 0) check("run_cycles", 80'(vcyc), 80'(sw));
        if (mode == 1) check("run_cycles", 80'(vcyc), 80'(2 * sw));
        @(negedge clk);
        #1;
        check("done_end", 80'(status_done), 80'(0));
        check("idle_ready", 80'(ctl_ready), 80'(1));
    endtask

    initial begin
        int sw, ox, iw, tw, y;
        #2;
        check("init_ready", 80'(ctl_ready), 80'(0));
        check("init_valid", 80'(pix_valid), 80'(0));
        check("init_done", 80'(status_done), 80'(0));
        check("init_x", 80'({pix_x, pix_tex_x, pix_tex_y}), 80'(0));
        @(negedge clk);
        nrst = 1'b1;

        g_oy = 3; g_ih = 6; g_th = 2;
        run_line(4, 8, 2, 4, 2, 0, -1, -1);
        run_line(4, 8, 2, 4, 2, 1, -1, -1);
        run_line(4, 0, 2, 4, 2, 0, -1, -1);
        run_line(5, 8, 2, 4, 2, 0, 3, -1);
        run_line(5, 8, 2, 4, 2, 0, -1, 3);
        run_line(5, 8, 2, 4, 2, 0, -1, -1);

        do_reset();
        g_oy = 1; g_ih = 4; g_th = 2;
        for (int i = 0; i < 6; i++) run_line(i, 8, 2, 4, 2, 0, -1, -1);

        do_reset();
        g_oy = 3; g_ih = 6; g_th = $urandom_range(0, 6);
        for (int i = 0; i < 40; i++) begin
            sw = $urandom_range(0, 16);
            ox = $urandom_range(0, 10);
            iw = $urandom_range(0, 12);
            tw = $urandom_range(0, iw);
            y  = $urandom_range(0, 12);
            run_line(y, sw, ox, iw, tw, $urandom_range(0, 2),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dc_ipu_line_request_responder.md
DC_IPU_LINE_REQUEST_RESPONDER -- requirements
Module: dc_ipu_line_request_responder

Interface
REQ-001 SHALL have parameters SCR_SIZE_WIDTH (default 12, coordinate width), SCALE_METHOD_WIDTH (default 2, scale method width) and RGB_WIDTH (default 24, colour width).
REQ-002 SHALL have ports clk (in, 1, clock) and nrst (in, 1, asynchronous active-low reset), where reset nrst is asynchronous and active-low and the clock is clk.
REQ-003 SHALL have port en (in, 1): global enable; while low, all state is frozen, ctl_ready=0 and pix_valid=0.
REQ-004 SHALL have the request side: ctl_valid (in, 1), ctl_ready (out, 1), ctl_screen_y, ctl_image_offset_x, ctl_image_offset_y, ctl_image_width, ctl_image_height, ctl_screen_width, ctl_tex_width and ctl_tex_height (all in, SCR_SIZE_WIDTH), ctl_scale_method (in, SCALE_METHOD_WIDTH), ctl_border_color (in, RGB_WIDTH) and status_done (out, 1, line complete pulse).
REQ-005 SHALL have the pixel side: pix_valid (out, 1), pix_ready (in, 1), pix_x, pix_y, pix_tex_x and pix_tex_y (out, SCR_SIZE_WIDTH), pix_is_border (out, 1), pix_color (out, RGB_WIDTH, border colour), pix_scale_method (out, SCALE_METHOD_WIDTH) and pix_last (out, 1, last pixel of line).

Function
REQ-006 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-007 In IDLE, ctl_ready SHALL be 1 (gated by en); ctl_valid&&ctl_ready SHALL latch all ctl_* fields, set x=0, move to RUN, or move to DONE if ctl_screen_width==0.
REQ-008 In RUN, pix_valid SHALL be 1 and the pixel fields SHALL be stable until pix_valid&&pix_ready; the first pix_valid SHALL come one cycle after request acceptance.
REQ-009 On each pixel handshake in RUN, x SHALL increment; the handshake with x==screen_width-1 (pix_last=1) SHALL move the FSM to DONE.
REQ-010 DONE SHALL last exactly one cycle with status_done=1 (registered), then return to IDLE; ctl_ready SHALL be 0 in RUN and DONE.
REQ-011 A pixel SHALL be in-image iff offset_x<=x<offset_x+image_width and offset_y<=screen_y<offset_y+image_height, with sums computed at SCR_SIZE_WIDTH+1 bits (no wrap).
REQ-012 A border pixel SHALL output pix_is_border=1, pix_color=border_color and pix_tex_x=pix_tex_y=0.
REQ-013 Horizontal DDA: at x==offset_x, tex_x=0 and acc_x=0; after each in-image handshake, acc_x+=tex_width, and if acc_x>=image_width then tex_x++ and acc_x-=image_width.
REQ-014 Vertical DDA, updated on request acceptance: if screen_y==offset_y then tex_y=0 and acc_y=0; else if the previous line was in-image then acc_y+=tex_height, and if acc_y>=image_height then tex_y++ and acc_y-=image_height.
REQ-015 The DDA accumulators SHALL be SCR_SIZE_WIDTH+1 bits; results are defined only for tex_width<=image_width and tex_height<=image_height (upscale only).
REQ-016 pix_y SHALL equal the latched screen_y and pix_scale_method SHALL equal the latched scale_method, passed through unchanged.
REQ-017 ctl_valid asserted in RUN or DONE SHALL be ignored until IDLE; a request SHALL never be lost while ctl_valid is held.
REQ-018 en deasserted mid-line SHALL pause the line with all counters and accumulators held, and resume on the next en=1 with the same pixel.

Reset
REQ-019 nrst low SHALL force IDLE, ctl_ready=0 for the reset cycle, status_done=0, pix_valid=0, and all latched fields, x, tex_x/tex_y and acc_x/acc_y to 0.
REQ-020 Reset mid-line SHALL abort the line with no status_done and no further pixels.

Structure
REQ-021 The FSM state encoding and the accumulator width (SCR_SIZE_WIDTH+1) SHALL live in the shared display-controller package.
REQ-022 One sub-module, dc_ipu_dda_stepper (accumulator, step, limit, restart, advance), SHALL be instantiated twice: once for x and once for y.

Verification
REQ-023 screen_width=8, offset_x=2, image_width=4, tex_width=2, pix_ready=1, screen_y in image -> pix_is_border=1,1,0,0,0,0,1,1; tex_x=0,0,1,1 in image; status_done exactly one cycle after the pix_last handshake.
REQ-024 Same line with pix_ready toggling 1,0 every cycle -> identical pixel sequence, fields stable while stalled, 16-cycle RUN.
REQ-025 Six consecutive requests screen_y=0..5, offset_y=1, image_height=4, tex_height=2 -> tex_y=0,0,1,1 for screen_y=1..4; screen_y=0 and 5 all border.
REQ-026 ctl_screen_width=0 -> no pix_valid; status_done one cycle after acceptance.
REQ-027 en=0 for 3 cycles mid-line -> pix_valid=0 and no handshakes during the pause, then the sequence resumes unchanged.
REQ-028 nrst pulse at pixel 3 of 8 -> IDLE, no status_done, next request restarts at x=0.
